// File: rtl/sample_loader_pkg.sv
// sample_loader_pkg: shared FSM state type and default parameters for the sample loader
package sample_loader_pkg;
  typedef enum logic {FILL = 1'b0, PRESENT = 1'b1} state_t;
  localparam int NSAMP         = 8;
  localparam int DEF_DATAWIDTH = 16;
  localparam int DEF_SHAMT     = 1;
endpackage

// File: rtl/sample_bank.sv
// sample_bank: eight-entry register bank, addressed write, async active-low clear
//   i_clk, i_rst_n : clock, async active-low clear
//   i_we, i_addr   : write enable and 3-bit entry address
//   i_wdata        : sample to store
//   o_q            : all eight stored samples
module sample_bank
  import sample_loader_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [2:0]           i_addr,
  input  logic [DATAWIDTH-1:0] i_wdata,
  output logic [DATAWIDTH-1:0] o_q [NSAMP]
);
  logic [DATAWIDTH-1:0] r_q [NSAMP];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) for (int i = 0; i < NSAMP; i++) r_q[i] <= '0;
    else if (i_we) r_q[i_addr] <= i_wdata;
  assign o_q = r_q;
endmodule

// File: rtl/sample_loader.sv
// sample_loader: gathers eight serial samples into a parallel frame with valid/ready handshake
//   Clk, Rst                    : clock, async active-low reset
//   in_data, in_valid, in_ready : serial sample input handshake
//   flush                       : discard partial or presented frame
//   a..h                        : frame samples in arrival order
//   sa                          : constant per-stage shift amount
//   frame_valid, frame_ready    : frame output handshake
//   frame_count                 : completed frame handshakes, wrapping
module sample_loader
  import sample_loader_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NSAMP     = 8,
  parameter int SHAMT     = DEF_SHAMT
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic signed [DATAWIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush,
  output logic signed [DATAWIDTH-1:0] a,
  output logic signed [DATAWIDTH-1:0] b,
  output logic signed [DATAWIDTH-1:0] c,
  output logic signed [DATAWIDTH-1:0] d,
  output logic signed [DATAWIDTH-1:0] e,
  output logic signed [DATAWIDTH-1:0] f,
  output logic signed [DATAWIDTH-1:0] g,
  output logic signed [DATAWIDTH-1:0] h,
  output logic [7:0]                  sa,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic [7:0]                  frame_count
);
  state_t               r_state, w_next;
  logic [2:0]           r_idx;
  logic [7:0]           r_count;
  logic                 w_accept, w_done;
  logic [DATAWIDTH-1:0] w_q [8];
  // flush wins over both a sample write and a frame handshake
  assign w_accept = in_valid && in_ready && !flush;
  assign w_done   = (r_state == PRESENT) && frame_ready && !flush;
  always_comb begin
    w_next      = r_state;
    in_ready    = (r_state == FILL);
    frame_valid = (r_state == PRESENT);
    if (flush) w_next = FILL;
    else if (w_accept && r_idx == 3'd7) w_next = PRESENT;
    else if (w_done) w_next = FILL;
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      r_state <= FILL;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= flush ? 3'd0 : w_accept ? r_idx + 3'd1 : r_idx;
      r_count <= w_done ? r_count + 8'd1 : r_count;
    end
  sample_bank #(.DATAWIDTH(DATAWIDTH)) u_bank (
    .i_clk   (Clk),
    .i_rst_n (Rst),
    .i_we    (w_accept),
    .i_addr  (r_idx),
    .i_wdata (in_data),
    .o_q     (w_q)
  );
  assign {a, b, c, d} = {w_q[0], w_q[1], w_q[2], w_q[3]};
  assign {e, f, g, h} = {w_q[4], w_q[5], w_q[6], w_q[7]};
  assign sa          = 8'(SHAMT);
  assign frame_count = r_count;
endmodule

// File: tb/tb_sample_loader.sv
// tb_sample_loader: table vectors, directed corner sequences and randomized run against a frame-level model
module tb_sample_loader;
  localparam int W = 16;
  logic Clk = 0, Rst = 0, in_valid = 0, flush = 0, frame_ready = 0;
  logic signed [W-1:0] in_data = 0;
  logic in_ready, frame_valid;
  logic [7:0] sa, frame_count;
  logic signed [W-1:0] a, b, c, d, e, f, g, h;
  logic signed [W-1:0] outs [8];
  int checks = 0, fails = 0;
  // model: sample slots, number of samples gathered, frame presented flag, handshake count
  logic signed [W-1:0] m_regs [8];
  int m_fill, m_count;
  bit m_valid;
  typedef struct {
    bit iv; int data; bit fr; bit fl;
    bit exp_ir; bit exp_fv; int exp_cnt;
  } vec_t;
  vec_t tbl [14];

  always #5 Clk = ~Clk;
  assign outs = '{a, b, c, d, e, f, g, h};

  sample_loader dut (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .sa(sa), .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_count(frame_count)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 0;
    m_fill = 0; m_valid = 0; m_count = 0;
  endtask

  // applies the frame-level rules to the inputs present before the coming edge
  task automatic model_edge();
    if (flush) begin
      m_fill = 0; m_valid = 0;
    end else if (m_valid) begin
      if (frame_ready) begin m_valid = 0; m_count = (m_count + 1) % 256; end
    end else if (in_valid) begin
      m_regs[m_fill] = in_data;
      m_fill++;
      if (m_fill == 8) begin m_fill = 0; m_valid = 1; end
    end
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, !m_valid);
    chk("frame_valid", frame_valid, m_valid);
    chk("frame_count", frame_count, m_count);
    chk("sa", sa, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("slot%0d", i), outs[i], m_regs[i]);
  endtask

  task automatic cycle(input bit iv, input int data, input bit fr, input bit fl);
    in_valid = iv; in_data = W'(data); frame_ready = fr; flush = fl;
    model_edge();
    @(posedge Clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    Rst = 0; #1;
    model_reset();
    chk("rst_fv", frame_valid, 0);
    chk("rst_cnt", frame_count, 0);
    chk("rst_sa", sa, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_slot%0d", i), outs[i], 0);
    in_valid = 0; flush = 0; frame_ready = 0;
    @(posedge Clk); #1; Rst = 1;
    chk("rst_ir", in_ready, 1);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) tbl[k] = '{1, k + 1, 0, 0, k != 7, k == 7, 0};
    for (int k = 8; k < 13; k++) tbl[k] = '{1, 99, 0, 0, 0, 1, 0};
    tbl[13] = '{0, 0, 1, 0, 1, 0, 1};
    #2; chk("sa_in_reset", sa, 1);
    do_reset();
    // frame 1..8, held five cycles, then handshake
    foreach (tbl[k]) begin
      in_valid = tbl[k].iv; in_data = W'(tbl[k].data); frame_ready = tbl[k].fr; flush = tbl[k].fl;
      model_edge();
      @(posedge Clk); #1;
      chk($sformatf("tbl%0d_ir", k), in_ready, tbl[k].exp_ir);
      chk($sformatf("tbl%0d_fv", k), frame_valid, tbl[k].exp_fv);
      chk($sformatf("tbl%0d_cnt", k), frame_count, tbl[k].exp_cnt);
      if (k >= 7)
        for (int i = 0; i < 8; i++) chk($sformatf("tbl%0d_slot%0d", k, i), outs[i], i + 1);
    end
    // signed extremes with an in_valid gap
    do_reset();
    cycle(1, -1, 0, 0); cycle(1, -2, 0, 0); cycle(1, 32767, 0, 0); cycle(0, 0, 0, 0);
    cycle(1, -32768, 0, 0); cycle(1, 0, 0, 0); cycle(1, 5, 0, 0); cycle(1, 6, 0, 0);
    cycle(1, 7, 0, 0);
    chk("sx_fv", frame_valid, 1);
    chk("sx_a", a, -1); chk("sx_c", c, 32767); chk("sx_d", d, -32768); chk("sx_h", h, 7);
    cycle(0, 0, 1, 0);
    chk("sx_fv_drop", frame_valid, 0);
    chk("sx_cnt", frame_count, 1);
    // flush after five samples, then a clean frame
    for (int k = 0; k < 5; k++) cycle(1, 100 + k, 0, 0);
    cycle(1, 200, 0, 1);
    for (int k = 0; k < 8; k++) cycle(1, 10 + k, 0, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("fl_slot%0d", i), outs[i], 10 + i);
    // flush with frame_ready while presented
    cycle(0, 0, 1, 1);
    chk("flfr_fv", frame_valid, 0);
    chk("flfr_ir", in_ready, 1);
    chk("flfr_cnt", frame_count, 1);
    // count wrap after 256 frames
    do_reset();
    for (int n = 0; n < 256; n++) begin
      for (int k = 0; k < 8; k++) cycle(1, n * 8 + k, 0, 0);
      cycle(0, 0, 1, 0);
    end
    chk("wrap_cnt", frame_count, 0);
    // reset mid-fill clears everything immediately
    cycle(1, 55, 0, 0); cycle(1, 66, 0, 0); cycle(1, 77, 0, 0);
    do_reset();
    // randomized traffic
    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sample_loader.md
SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter NSAMP, default 8, samples per frame; fixed at 8 in this release.
REQ-003 SHALL have parameter SHAMT, default 1, per-stage shift amount driven on sa (three stages of 1 give divide-by-8).
REQ-004 SHALL have port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port Rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  DATAWIDTH  signed serial sample.
REQ-007 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  loader accepts a sample this cycle.
REQ-009 SHALL have port flush  input  1  synchronous discard of any partial or presented frame.
REQ-010 SHALL have ports a, b, c, d, e, f, g, h  output  DATAWIDTH each  signed frame samples, in arrival order.
REQ-011 SHALL have port sa  output  8  constant SHAMT, zero-extended.
REQ-012 SHALL have port frame_valid  output  1  a..h hold a complete frame.
REQ-013 SHALL have port frame_ready  input  1  consumer takes the frame this cycle.
REQ-014 SHALL have port frame_count  output  8  count of completed frame handshakes.

Function
REQ-015 SHALL use a two-state FSM: FILL and PRESENT.
REQ-016 In FILL, in_ready SHALL be 1 and frame_valid SHALL be 0.
REQ-017 A sample SHALL be accepted only when in_valid and in_ready are both 1 on a rising edge.
REQ-018 Accepted sample k (k = 0..7, counted since the last frame start) SHALL be written to output a, b, c, d, e, f, g, h respectively.
REQ-019 A 3-bit fill index SHALL increment per accepted sample; on acceptance of sample 7 the FSM SHALL enter PRESENT and the index SHALL return to 0.
REQ-020 frame_valid SHALL assert the cycle after sample 7 is accepted (latency 1).
REQ-021 In PRESENT, in_ready SHALL be 0 and a..h SHALL be held stable.
REQ-022 In PRESENT, frame_ready = 1 SHALL complete the handshake: next cycle the FSM is in FILL, frame_valid is 0 and in_ready is 1; there is no same-cycle bypass.
REQ-023 frame_count SHALL increment by 1 on each completed handshake and wrap 255 -> 0.
REQ-024 flush = 1 SHALL, next cycle, force FILL with fill index 0 and frame_valid 0, and SHALL leave a..h and frame_count unchanged.
REQ-025 flush SHALL take priority over a simultaneous sample acceptance or frame handshake; that sample or frame is discarded and frame_count is not incremented.
REQ-026 frame_ready SHALL be ignored in FILL.
REQ-027 a..h SHALL be plain register outputs with no arithmetic; sign is preserved bit-exact.

Reset
REQ-028 While Rst = 0, the loader SHALL immediately clear FSM to FILL, fill index to 0, a..h to 0, frame_valid to 0 and frame_count to 0, and SHALL drive in_ready to 1 after release.
REQ-029 Reset asserted mid-frame or during PRESENT SHALL discard the frame with no handshake counted.
REQ-030 sa SHALL equal SHAMT at all times, including during reset.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (FILL, PRESENT), NSAMP and the default DATAWIDTH and SHAMT.
REQ-032 The sample bank SHALL be one sub-module, sample_bank: eight DATAWIDTH registers with write-enable and 3-bit address, async active-low clear.
REQ-033 The FSM, fill index and frame counter SHALL reside in sample_loader.

Verification
REQ-034 Reset then 8 samples 1..8 back-to-back, frame_ready = 0 -> a=1 ... h=8, frame_valid = 1 one cycle after the 8th, in_ready = 0, outputs held for 5 cycles.
REQ-035 Samples -1, -2, 32767, -32768, 0, 5, 6, 7 with a gap in in_valid after the 3rd, then frame_ready = 1 -> values bit-exact, frame_valid drops next cycle, frame_count = 1.
REQ-036 Flush after 5 samples, then samples 10..17 -> a=10 ... h=17 and no contamination from the flushed samples.
REQ-037 flush and frame_ready both asserted in PRESENT -> FILL next cycle, frame_count unchanged.
REQ-038 256 complete frames -> frame_count wraps to 0; Rst pulsed low mid-fill -> all outputs 0 immediately and sa = SHAMT throughout.
